// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared interrupt-sequencer state encoding and CP0 register map
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SAVE_EPC   = 3'd1,
      SAVE_CAUSE = 3'd2,
      MASK_SR    = 3'd3,
      JUMP       = 3'd4,
      ERET_SR    = 3'd5,
      ERET_JUMP  = 3'd6
   } int_state_t;

   localparam logic [4:0]  C_CP0_PRID  = 5'd8;
   localparam logic [4:0]  C_CP0_SR    = 5'd12;
   localparam logic [4:0]  C_CP0_CAUSE = 5'd13;
   localparam logic [4:0]  C_CP0_EPC   = 5'd14;

   // Status value restored by ERET: all six lines unmasked, IE set.
   localparam logic [31:0] C_ERET_SR   = 32'h0000_FC01;

   // Isolate the lowest set bit so the lowest-numbered line wins.
   function automatic logic [5:0] lowest_set(input logic [5:0] v);
      return v & (~v + 6'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_edge.sv
// ---------------------------------------------------------------------------
// irq_edge : two-flop synchronizer plus rising-edge detector per irq line
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_edge #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] irq,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= irq;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign rise = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl : interrupt entry / ERET sequencer driving CP0 writes and PC redirect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module int_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008,
   parameter int          NIRQ         = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] irq,
   input  logic [15:0]     sr,
   input  logic [31:0]     epc,
   input  logic [31:0]     pc,
   input  logic            boundary,
   input  logic            eret,
   output logic [4:0]      cp0_addr,
   output logic            cp0_we,
   output logic            cp0_writeSrc,
   output logic [31:0]     cp0_din,
   output logic            stall,
   output logic            redirect,
   output logic [31:0]     redirect_pc
);

   int_state_t      r_state;
   int_state_t      w_next;
   logic [NIRQ-1:0] r_pending;
   logic [NIRQ-1:0] w_rise;
   logic [NIRQ-1:0] w_clr;
   logic [31:0]     r_pc;
   logic [5:0]      r_onehot;
   logic [5:0]      w_cand;
   logic [5:0]      w_sel;
   logic            w_take;
   logic            w_latch;

   irq_edge #(
      .WIDTH (NIRQ)
   ) u_irq_edge (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq),
      .rise (w_rise)
   );

   // Pending lines are viewed through the six IM bits of SR[15:10].
   assign w_cand = 6'(r_pending) & sr[15:10];
   assign w_sel  = lowest_set(w_cand);
   assign w_take = boundary & sr[0] & (|w_cand);
   assign w_clr  = (r_state == JUMP) ? NIRQ'(r_onehot) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_pc      <= '0;
         r_onehot  <= '0;
      end else begin
         r_state   <= w_next;
         // A fresh edge wins over the clear of the same line.
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (w_latch) begin
            r_pc     <= pc;
            r_onehot <= w_sel;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_latch      = 1'b0;
      cp0_addr     = 5'd0;
      cp0_we       = 1'b0;
      cp0_writeSrc = 1'b0;
      cp0_din      = 32'd0;
      stall        = 1'b1;
      redirect     = 1'b0;
      redirect_pc  = 32'd0;
      case (r_state)
         IDLE: begin
            stall = 1'b0;
            // ERET has priority; the interrupt stays pending for later.
            if (eret) begin
               w_next = ERET_SR;
            end else if (w_take) begin
               w_next  = SAVE_EPC;
               w_latch = 1'b1;
            end
         end
         SAVE_EPC: begin
            cp0_we   = 1'b1;
            cp0_addr = C_CP0_EPC;
            cp0_din  = r_pc;
            w_next   = SAVE_CAUSE;
         end
         SAVE_CAUSE: begin
            cp0_we   = 1'b1;
            cp0_addr = C_CP0_CAUSE;
            cp0_din  = {16'b0, r_onehot, 10'b0};
            w_next   = MASK_SR;
         end
         MASK_SR: begin
            cp0_we   = 1'b1;
            cp0_addr = C_CP0_SR;
            cp0_din  = {16'b0, sr & 16'hFFFE};
            w_next   = JUMP;
         end
         JUMP: begin
            redirect    = 1'b1;
            redirect_pc = HANDLER_ADDR;
            w_next      = IDLE;
         end
         ERET_SR: begin
            cp0_we       = 1'b1;
            cp0_writeSrc = 1'b1;
            cp0_addr     = C_CP0_SR;
            cp0_din      = C_ERET_SR;
            w_next       = ERET_JUMP;
         end
         ERET_JUMP: begin
            redirect    = 1'b1;
            redirect_pc = epc;
            w_next      = IDLE;
         end
         default: begin
            stall  = 1'b0;
            w_next = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_ctrl : scoreboard bench for the interrupt entry / ERET sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_int_ctrl;

   localparam logic [31:0] HADDR = 32'h0000_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  irq;
   logic [15:0] sr;
   logic [31:0] epc;
   logic [31:0] pc;
   logic        boundary;
   logic        eret;
   logic [4:0]  cp0_addr;
   logic        cp0_we;
   logic        cp0_writeSrc;
   logic [31:0] cp0_din;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;

   typedef struct {
      logic        redir;
      logic [4:0]  addr;
      logic [31:0] val;
      logic        src;
      int          cyc;
   } ev_t;

   ev_t sb[$];
   ev_t e;
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   int_ctrl #(
      .HANDLER_ADDR (HADDR),
      .NIRQ         (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .irq          (irq),
      .sr           (sr),
      .epc          (epc),
      .pc           (pc),
      .boundary     (boundary),
      .eret         (eret),
      .cp0_addr     (cp0_addr),
      .cp0_we       (cp0_we),
      .cp0_writeSrc (cp0_writeSrc),
      .cp0_din      (cp0_din),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Every CP0 write or redirect is matched against the next expected event.
   always begin
      @(posedge clk);
      #1;
      if (!rst && (cp0_we || redirect)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d got we=%0b addr=%0d din=%h redirect=%0b rpc=%h want no event",
                     cyc, cp0_we, cp0_addr, cp0_din, redirect, redirect_pc);
         end else begin
            e = sb.pop_front();
            if (e.redir) begin
               if (redirect !== 1'b1 || cp0_we !== 1'b0 || redirect_pc !== e.val || stall !== 1'b1 ||
                   (e.cyc >= 0 && cyc != e.cyc)) begin
                  bad++;
                  $display("FAIL redirect cyc=%0d got redirect=%0b we=%0b rpc=%h stall=%0b want redirect=1 rpc=%h cyc=%0d",
                           cyc, redirect, cp0_we, redirect_pc, stall, e.val, e.cyc);
               end
            end else begin
               if (cp0_we !== 1'b1 || redirect !== 1'b0 || cp0_addr !== e.addr || cp0_din !== e.val ||
                   cp0_writeSrc !== e.src || stall !== 1'b1 || (e.cyc >= 0 && cyc != e.cyc)) begin
                  bad++;
                  $display("FAIL cp0_write cyc=%0d got we=%0b addr=%0d din=%h src=%0b stall=%0b want addr=%0d din=%h src=%0b cyc=%0d",
                           cyc, cp0_we, cp0_addr, cp0_din, cp0_writeSrc, stall, e.addr, e.val, e.src, e.cyc);
               end
            end
         end
      end
   end

   task automatic push_wr(input logic [4:0] a, input logic [31:0] v, input logic s, input int c);
      ev_t x;
      x.redir = 1'b0; x.addr = a; x.val = v; x.src = s; x.cyc = c;
      sb.push_back(x);
   endtask

   task automatic push_rd(input logic [31:0] v, input int c);
      ev_t x;
      x.redir = 1'b1; x.addr = 5'd0; x.val = v; x.src = 1'b0; x.cyc = c;
      sb.push_back(x);
   endtask

   // Standard entry: EPC at c, CAUSE c+1, SR c+2, redirect c+3.
   task automatic push_entry(input logic [31:0] p, input int line, input logic [15:0] s, input int c);
      push_wr(5'd14, p, 1'b0, c);
      push_wr(5'd13, 32'h1 << (10 + line), 1'b0, c + 1);
      push_wr(5'd12, {16'b0, s & 16'hFFFE}, 1'b0, c + 2);
      push_rd(HADDR, c + 3);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s drain_timeout left=%0d want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; irq = '0; sr = 16'h0; epc = '0; pc = '0; boundary = 1'b0; eret = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({stall, cp0_we, cp0_writeSrc, redirect} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_strobes got %b want 0000", {stall, cp0_we, cp0_writeSrc, redirect});
      end
      total++;
      if (cp0_din !== 32'd0) begin
         bad++; $display("FAIL reset_din got %h want 0", cp0_din);
      end
      total++;
      if (redirect_pc !== 32'd0) begin
         bad++; $display("FAIL reset_rpc got %h want 0", redirect_pc);
      end
      total++;
      if (cp0_addr !== 5'd0) begin
         bad++; $display("FAIL reset_addr got %0d want 0", cp0_addr);
      end
      rst = 1'b0; sr = 16'hFC01; boundary = 1'b1; pc = 32'h100;
      repeat (3) @(negedge clk);
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL idle_stall got %0b want 0", stall);
      end
   endtask

   task automatic test_basic;
      int n;
      @(negedge clk);
      n = cyc;
      irq[2] = 1'b1;
      push_entry(32'h100, 2, 16'hFC01, n + 4);
      drain("basic", 20);
      irq = '0;
   endtask

   task automatic test_masked;
      int n;
      int m;
      @(negedge clk);
      sr = 16'hDC01;
      pc = 32'h120;
      n = cyc;
      irq[3] = 1'b1;
      wait_to(n + 10);
      total++;
      if (stall !== 1'b0 || sb.size() != 0) begin
         bad++; $display("FAIL masked_no_take got stall=%0b want 0", stall);
      end
      m = cyc;
      sr = 16'hFC01;
      push_entry(32'h120, 3, 16'hFC01, m + 1);
      drain("masked", 20);
      irq = '0;
   endtask

   task automatic test_priority;
      int n;
      int m;
      @(negedge clk);
      pc = 32'h140;
      n = cyc;
      irq[1] = 1'b1;
      irq[4] = 1'b1;
      push_entry(32'h140, 1, 16'hFC01, n + 4);
      wait_to(n + 6);
      sr = 16'hFC00;
      drain("priority_first", 20);
      repeat (5) @(negedge clk);
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL priority_ie_off got stall=%0b want 0", stall);
      end
      pc = 32'h180;
      m = cyc;
      sr = 16'hFC01;
      push_entry(32'h180, 4, 16'hFC01, m + 1);
      drain("priority_second", 20);
      irq = '0;
   endtask

   task automatic test_eret;
      int n;
      int cnt;
      cnt = 0;
      @(negedge clk);
      epc = 32'h200;
      n = cyc;
      eret = 1'b1;
      push_wr(5'd12, 32'h0000_FC01, 1'b1, n + 1);
      push_rd(32'h200, n + 2);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) eret = 1'b0;
         if (stall === 1'b1) cnt++;
      end
      total++;
      if (cnt != 2) begin
         bad++; $display("FAIL eret_stall_cycles got %0d want 2", cnt);
      end
      drain("eret", 10);
   endtask

   task automatic test_eret_and_take;
      int n;
      int m;
      @(negedge clk);
      sr = 16'hFC00;
      pc = 32'h1C0;
      epc = 32'h240;
      n = cyc;
      irq[0] = 1'b1;
      wait_to(n + 4);
      m = cyc;
      eret = 1'b1;
      sr = 16'hFC01;
      push_wr(5'd12, 32'h0000_FC01, 1'b1, m + 1);
      push_rd(32'h240, m + 2);
      push_entry(32'h1C0, 0, 16'hFC01, m + 4);
      @(posedge clk);
      #1;
      eret = 1'b0;
      drain("eret_take", 20);
      irq = '0;
   endtask

   task automatic test_reset_mid;
      int n;
      @(negedge clk);
      pc = 32'h2C0;
      n = cyc;
      irq[5] = 1'b1;
      push_wr(5'd14, 32'h2C0, 1'b0, n + 4);
      push_wr(5'd13, 32'h0000_8000, 1'b0, n + 5);
      wait_to(n + 5);
      total++;
      if (cp0_addr !== 5'd13 || cp0_we !== 1'b1) begin
         bad++; $display("FAIL mid_in_cause got addr=%0d we=%0b want 13 1", cp0_addr, cp0_we);
      end
      rst = 1'b1;
      irq = '0;
      #1;
      total++;
      if ({stall, cp0_we, cp0_writeSrc, redirect} !== 4'b0000 || cp0_din !== 32'd0 ||
          redirect_pc !== 32'd0 || cp0_addr !== 5'd0) begin
         bad++;
         $display("FAIL mid_reset_outputs got strobes=%b din=%h rpc=%h addr=%0d want all 0",
                  {stall, cp0_we, cp0_writeSrc, redirect}, cp0_din, redirect_pc, cp0_addr);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (stall !== 1'b0 || sb.size() != 0) begin
         bad++; $display("FAIL mid_reset_quiet got stall=%0b left=%0d want 0 0", stall, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_masked();
      test_priority();
      test_eret();
      test_eret_and_take();
      test_reset_mid();
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL final_queue got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
